// File: rtl/router_wrap_vc_input_buffer.sv
// router_wrap_vc_input_buffer
//
// Input-port buffer for a router_wrap tile. Upstream flits are stored in
// per-VC FIFOs. A round-robin arbiter presents one FIFO head to the switch
// using valid/ready. Each dequeue returns one registered credit upstream.
//
// Ports:
//   clk            tile clock
//   reset          asynchronous active-low reset
//   channel_in     {valid, vc, head, tail, data}, MSB first
//   flow_ctrl_out  {credit_valid, credit_vc}, registered, one cycle after a pop
//   flit_out_*     arbitrated first-word-fall-through flit and its handshake
//   vc_nonempty    per-VC occupancy != 0
//   error          sticky: overflow, plus framing violations when enabled
//
// Build option:
//   ROUTER_WRAP_PKT_CHECK_EN  adds per-VC head/tail framing checks on the
//                             write side. When it is undefined, error flags
//                             overflow only.
module router_wrap_vc_input_buffer #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_VCS    = 4,
  parameter int unsigned VC_IDX_W   = $clog2(NUM_VCS),
  parameter int unsigned DEPTH      = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [3+VC_IDX_W+DATA_WIDTH-1:0] channel_in,
  output logic [VC_IDX_W:0]                flow_ctrl_out,
  output logic                             flit_out_valid,
  input  logic                             flit_out_ready,
  output logic [VC_IDX_W-1:0]              flit_out_vc,
  output logic                             flit_out_head,
  output logic                             flit_out_tail,
  output logic [DATA_WIDTH-1:0]            flit_out_data,
  output logic [NUM_VCS-1:0]               vc_nonempty,
  output logic                             error
);

  localparam int unsigned PTR_W     = $clog2(DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned ENTRY_W   = DATA_WIDTH + 2;
  localparam int unsigned VALID_BIT = DATA_WIDTH + 2 + VC_IDX_W;

  // StFree: the grant is re-evaluated each cycle from occupancy and the rr
  //         pointer. flit_out_valid is 0 when nothing is queued (idle).
  // StHold: a presented flit was not accepted, so its grant is pinned.
  typedef enum logic [0:0] {StFree, StHold} arb_state_e;

  // Input channel fields
  logic                  in_valid;
  logic [VC_IDX_W-1:0]   in_vc;
  logic                  in_head;
  logic                  in_tail;
  logic [DATA_WIDTH-1:0] in_data;

  assign in_valid = channel_in[VALID_BIT];
  assign in_vc    = channel_in[DATA_WIDTH+2 +: VC_IDX_W];
  assign in_head  = channel_in[DATA_WIDTH+1];
  assign in_tail  = channel_in[DATA_WIDTH];
  assign in_data  = channel_in[DATA_WIDTH-1:0];

  // FIFO storage and bookkeeping
  logic [ENTRY_W-1:0] mem_q    [NUM_VCS][DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q [NUM_VCS];
  logic [PTR_W-1:0]   rd_ptr_q [NUM_VCS];
  logic [CNT_W-1:0]   cnt_q    [NUM_VCS];
  logic [CNT_W-1:0]   cnt_d    [NUM_VCS];

  logic [NUM_VCS-1:0] vc_full;
  logic [NUM_VCS-1:0] nonempty;
  logic [NUM_VCS-1:0] wr_en;
  logic [NUM_VCS-1:0] pop;
  logic               overflow;
  logic               frame_err;

  // Arbiter
  arb_state_e          state_q, state_d;
  logic [VC_IDX_W-1:0] rr_q, rr_d;
  logic [VC_IDX_W-1:0] hold_vc_q, hold_vc_d;
  logic [VC_IDX_W-1:0] arb_idx;
  logic [VC_IDX_W-1:0] arb_vc;
  logic                arb_found;
  logic                grant_valid;
  logic [VC_IDX_W-1:0] grant_vc;
  logic                handshake;
  logic [ENTRY_W-1:0]  head_entry;

  // Credit and error state
  logic [VC_IDX_W:0] credit_q, credit_d;
  logic              error_q, error_d;

  // Full is judged on the registered count, before this cycle's pop. A
  // write to a full VC is dropped even when that VC is being read.
  always_comb begin
    vc_full  = '0;
    nonempty = '0;
    wr_en    = '0;
    pop      = '0;
    for (int unsigned v = 0; v < NUM_VCS; v++) begin
      vc_full[v]  = (cnt_q[v] == CNT_W'(DEPTH));
      nonempty[v] = (cnt_q[v] != '0);
      wr_en[v]    = in_valid && (in_vc == VC_IDX_W'(v)) && !vc_full[v];
      pop[v]      = handshake && (grant_vc == VC_IDX_W'(v));
      cnt_d[v]    = cnt_q[v] + CNT_W'(wr_en[v]) - CNT_W'(pop[v]);
    end
  end

  assign overflow = in_valid && vc_full[in_vc];

  // First nonempty VC at or after the rr pointer. The index wraps
  // naturally because NUM_VCS is a power of two.
  always_comb begin
    arb_found = 1'b0;
    arb_vc    = '0;
    arb_idx   = '0;
    for (int unsigned k = 0; k < NUM_VCS; k++) begin
      arb_idx = rr_q + VC_IDX_W'(k);
      if (!arb_found && nonempty[arb_idx]) begin
        arb_found = 1'b1;
        arb_vc    = arb_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_vc_d   = hold_vc_q;
    grant_valid = 1'b0;
    grant_vc    = '0;
    unique case (state_q)
      StFree: begin
        grant_valid = arb_found;
        grant_vc    = arb_vc;
      end
      StHold: begin
        // The held VC cannot drain without a handshake, so it is still nonempty.
        grant_valid = 1'b1;
        grant_vc    = hold_vc_q;
      end
      default: begin
        grant_valid = 1'b0;
        grant_vc    = '0;
      end
    endcase
    if (grant_valid && !flit_out_ready) begin
      state_d   = StHold;
      hold_vc_d = grant_vc;
    end else begin
      state_d = StFree;
    end
  end

  assign handshake = grant_valid && flit_out_ready;
  assign rr_d      = handshake ? grant_vc + VC_IDX_W'(1) : rr_q;
  assign credit_d  = handshake ? {1'b1, grant_vc} : '0;
  assign error_d   = error_q | overflow | frame_err;

  // Output path: read from registered state only, with no bypass from channel_in.
  assign head_entry     = mem_q[grant_vc][rd_ptr_q[grant_vc]];
  assign flit_out_valid = grant_valid;
  assign flit_out_vc    = grant_vc;
  assign flit_out_head  = head_entry[DATA_WIDTH+1];
  assign flit_out_tail  = head_entry[DATA_WIDTH];
  assign flit_out_data  = head_entry[DATA_WIDTH-1:0];
  assign flow_ctrl_out  = credit_q;
  assign vc_nonempty    = nonempty;
  assign error          = error_q;

`ifdef ROUTER_WRAP_PKT_CHECK_EN
  logic [NUM_VCS-1:0] in_pkt_q, in_pkt_d;

  // A head is legal only outside a packet, and a body/tail flit only inside
  // one. The flag follows every presented flit, including dropped ones.
  always_comb begin
    in_pkt_d  = in_pkt_q;
    frame_err = 1'b0;
    if (in_valid) begin
      if (in_head == in_pkt_q[in_vc]) begin
        frame_err = 1'b1;
      end
      if (in_tail) begin
        in_pkt_d[in_vc] = 1'b0;
      end else if (in_head) begin
        in_pkt_d[in_vc] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_pkt_q <= '0;
    end else begin
      in_pkt_q <= in_pkt_d;
    end
  end
`else
  assign frame_err = 1'b0;
`endif

  // Storage needs no reset: the counts gate visibility.
  always_ff @(posedge clk) begin
    for (int unsigned v = 0; v < NUM_VCS; v++) begin
      if (wr_en[v]) begin
        mem_q[v][wr_ptr_q[v]] <= {in_head, in_tail, in_data};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned v = 0; v < NUM_VCS; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        cnt_q[v]    <= '0;
      end
      state_q   <= StFree;
      hold_vc_q <= '0;
      rr_q      <= '0;
      credit_q  <= '0;
      error_q   <= 1'b0;
    end else begin
      for (int unsigned v = 0; v < NUM_VCS; v++) begin
        if (wr_en[v]) begin
          wr_ptr_q[v] <= wr_ptr_q[v] + PTR_W'(1);
        end
        if (pop[v]) begin
          rd_ptr_q[v] <= rd_ptr_q[v] + PTR_W'(1);
        end
        cnt_q[v] <= cnt_d[v];
      end
      state_q   <= state_d;
      hold_vc_q <= hold_vc_d;
      rr_q      <= rr_d;
      credit_q  <= credit_d;
      error_q   <= error_d;
    end
  end

endmodule

// File: tb/tb_router_wrap_vc_input_buffer.sv
// Testbench for router_wrap_vc_input_buffer.
// The bench runs directed scenarios and then a randomized traffic phase.
// A negedge monitor holds a queue-based reference model. It predicts the
// presented flit, the credits, occupancy and the sticky error flag.
module tb_router_wrap_vc_input_buffer;

  localparam int DW    = 64;
  localparam int NV    = 4;
  localparam int VW    = 2;
  localparam int DEPTH = 8;
  localparam int CW    = 3 + VW + DW;
`ifdef ROUTER_WRAP_PKT_CHECK_EN
  localparam bit PKT_CHECK = 1'b1;
`else
  localparam bit PKT_CHECK = 1'b0;
`endif

  typedef logic [DW+1:0] flit_t;  // {head, tail, data}

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [CW-1:0] channel_in = '0;
  logic [VW:0]   flow_ctrl_out;
  logic          flit_out_valid;
  logic          flit_out_ready = 1'b0;
  logic [VW-1:0] flit_out_vc;
  logic          flit_out_head;
  logic          flit_out_tail;
  logic [DW-1:0] flit_out_data;
  logic [NV-1:0] vc_nonempty;
  logic          error;

  router_wrap_vc_input_buffer #(
    .DATA_WIDTH(DW),
    .NUM_VCS   (NV),
    .DEPTH     (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .channel_in    (channel_in),
    .flow_ctrl_out (flow_ctrl_out),
    .flit_out_valid(flit_out_valid),
    .flit_out_ready(flit_out_ready),
    .flit_out_vc   (flit_out_vc),
    .flit_out_head (flit_out_head),
    .flit_out_tail (flit_out_tail),
    .flit_out_data (flit_out_data),
    .vc_nonempty   (vc_nonempty),
    .error         (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model state
  flit_t         mq[NV][$];
  logic [VW-1:0] cq[$];       // expected credits, in order
  int            rr = 0;
  bit            held = 1'b0;
  int            held_vc = 0;
  bit            exp_err = 1'b0;
  bit            in_pkt[NV];
  int            dut_hs = 0;   // DUT handshakes observed
  int            dut_cred = 0; // DUT credits observed

  function automatic bit model_empty();
    for (int k = 0; k < NV; k++) if (mq[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge clk) begin : monitor
    int            g;
    bit            ev;
    bit            full;
    int            wvc;
    logic [NV-1:0] ene;
    logic [VW:0]   ecr;
    logic [VW-1:0] cv;
    flit_t         wf;
    if (!reset) begin
      for (int k = 0; k < NV; k++) begin
        mq[k].delete();
        in_pkt[k] = 1'b0;
      end
      cq.delete();
      rr = 0; held = 1'b0; exp_err = 1'b0;
      check("rst_valid", flit_out_valid, 0);
      check("rst_credit", flow_ctrl_out, 0);
      check("rst_error", error, 0);
      check("rst_nonempty", vc_nonempty, 0);
    end else begin
      // The expected grant depends only on state settled at the last edge.
      ev = 1'b0; g = 0;
      if (held) begin
        ev = 1'b1; g = held_vc;
      end else begin
        for (int k = 0; k < NV; k++) begin
          if (!ev && mq[(rr + k) % NV].size() > 0) begin
            ev = 1'b1; g = (rr + k) % NV;
          end
        end
      end
      check("valid", flit_out_valid, ev);
      if (ev && flit_out_valid) begin
        check("vc", flit_out_vc, g);
        check("payload", {flit_out_head, flit_out_tail, flit_out_data}, mq[g][0]);
      end
      ene = '0;
      for (int k = 0; k < NV; k++) ene[k] = (mq[k].size() > 0);
      check("nonempty", vc_nonempty, ene);
      check("error", error, exp_err);
      ecr = '0;
      if (cq.size() > 0) begin
        cv  = cq.pop_front();
        ecr = {1'b1, cv};
      end
      check("credit", flow_ctrl_out, ecr);
      if (flit_out_valid && flit_out_ready) dut_hs++;
      if (flow_ctrl_out[VW]) dut_cred++;

      // Advance the model across the coming edge. Full is judged before the pop.
      full = 1'b0;
      wvc  = int'(channel_in[DW+2 +: VW]);
      if (channel_in[CW-1]) full = (mq[wvc].size() == DEPTH);
      if (ev && flit_out_ready) begin
        void'(mq[g].pop_front());
        rr = (g + 1) % NV;
        cq.push_back(VW'(g));
      end
      held    = ev && !flit_out_ready;
      held_vc = g;
      if (channel_in[CW-1]) begin
        wf = channel_in[DW+1:0];
        if (full) exp_err = 1'b1;
        else mq[wvc].push_back(wf);
        if (PKT_CHECK) begin
          if (wf[DW+1] == in_pkt[wvc]) exp_err = 1'b1;
          if (wf[DW]) in_pkt[wvc] = 1'b0;
          else if (wf[DW+1]) in_pkt[wvc] = 1'b1;
        end
      end
    end
  end

  function automatic logic [CW-1:0] mk(input int vc, input bit h, input bit t,
                                       input logic [DW-1:0] d);
    logic [VW-1:0] v;
    v = vc[VW-1:0];
    return {1'b1, v, h, t, d};
  endfunction

  // Drive one cycle, then return just after the next active edge.
  task automatic cyc(input logic [CW-1:0] ch, input bit rdy);
    channel_in     = ch;
    flit_out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    channel_in     = '0;
    flit_out_ready = 1'b0;
    reset          = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic drain(input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      cyc('0, 1'b1);
      done = model_empty() && (cq.size() == 0);
    end
    check({nm, "_drain"}, done, 1);
    check({nm, "_idle_nonempty"}, vc_nonempty, 0);
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin : stim
    bit            drv_pkt[NV];
    int            v;
    bit            h;
    bit            t;
    logic [CW-1:0] ch;

    // Reset, then idle for 10 cycles
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) cyc('0, 1'b0);
    check("idle_valid", flit_out_valid, 0);
    check("idle_error", error, 0);

    // Single flit on VC2: visible next cycle, credit the cycle after
    cyc(mk(2, 1, 1, 64'hA5A5_0000_0000_0001), 1'b1);
    check("t2_valid", flit_out_valid, 1);
    check("t2_data", flit_out_data, 64'hA5A5_0000_0000_0001);
    cyc('0, 1'b1);
    check("t2_credit", flow_ctrl_out, 3'b110);
    drain("t2");

    // One flit per VC in a burst, stalled, then drained in rr order
    for (int k = 0; k < NV; k++) cyc(mk(k, 1, 1, rnd64()), 1'b0);
    repeat (1) cyc('0, 1'b0);
    dut_cred = 0;
    drain("t3");
    check("t3_credits", dut_cred, 4);

    // Overflow VC1
    for (int k = 0; k < DEPTH; k++) cyc(mk(1, 1, 1, rnd64()), 1'b0);
    cyc(mk(1, 1, 1, 64'hDEAD_BEEF_0000_0009), 1'b0);
    cyc('0, 1'b0);
    check("t4_error", error, 1);
    dut_hs = 0; dut_cred = 0;
    drain("t4");
    check("t4_flits", dut_hs, DEPTH);
    check("t4_credits", dut_cred, DEPTH);
    do_reset();

    // Write and pop the same full VC in one cycle
    for (int k = 0; k < DEPTH; k++) cyc(mk(3, 1, 1, rnd64()), 1'b0);
    cyc(mk(3, 1, 1, 64'h0BAD_0BAD_0BAD_0BAD), 1'b1);
    check("t5_error", error, 1);
    dut_hs = 0;
    drain("t5");
    check("t5_remaining", dut_hs, DEPTH - 1);
    do_reset();

    // Head followed by head on VC0
    cyc(mk(0, 1, 0, rnd64()), 1'b0);
    cyc(mk(0, 1, 0, rnd64()), 1'b0);
    cyc('0, 1'b0);
    check("t6_framing_err", error, PKT_CHECK);
    drain("t6");
    do_reset();

    // Randomized well-framed traffic with random backpressure
    for (int k = 0; k < NV; k++) drv_pkt[k] = 1'b0;
    for (int i = 0; i < 800; i++) begin
      ch = '0;
      if ($urandom_range(0, 9) < 6) begin
        v = $urandom_range(0, NV - 1);
        h = !drv_pkt[v];
        t = h ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 2) == 0);
        drv_pkt[v] = !t;
        ch = mk(v, h, t, rnd64());
      end
      cyc(ch, $urandom_range(0, 9) < 6);
    end
    drain("rand");

    // Reset with flits queued: nothing may emerge afterwards
    for (int k = 0; k < 5; k++) cyc(mk(k % NV, 1, 1, rnd64()), 1'b0);
    do_reset();
    dut_hs = 0; dut_cred = 0;
    repeat (6) cyc('0, 1'b1);
    check("midrst_flits", dut_hs, 0);
    check("midrst_credits", dut_cred, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
